// File: rtl/alu_rs_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_scheduler_pkg
//  Description : Shared widths, entry record and CDB snoop helpers for the
//                ALU reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_scheduler_pkg;

  // Bus widths shared with the rest of the core
  localparam int OP_ID_W  = 6;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int IMM_W    = 32;

  // One reservation-station slot (busy bit is kept separately as a vector)
  typedef struct packed {
    logic [OP_ID_W-1:0]  op;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   vj;
    logic [DATA_W-1:0]   vk;
    logic                qj_busy;
    logic [ROB_ID_W-1:0] qj;
    logic                qk_busy;
    logic [ROB_ID_W-1:0] qk;
    logic [IMM_W-1:0]    imm;
    logic [ROB_ID_W-1:0] rob_id;
  } rs_entry_t;

  // True when either broadcast bus carries the requested tag
  function automatic logic cdb_hit(
    input logic                alu_v,
    input logic [ROB_ID_W-1:0] alu_tag,
    input logic                lsb_v,
    input logic [ROB_ID_W-1:0] lsb_tag,
    input logic [ROB_ID_W-1:0] tag
  );
    return (alu_v && (alu_tag == tag)) || (lsb_v && (lsb_tag == tag));
  endfunction

  // Broadcast value for a tag; the ALU bus wins when both buses match
  function automatic logic [DATA_W-1:0] cdb_value(
    input logic                alu_v,
    input logic [ROB_ID_W-1:0] alu_tag,
    input logic [DATA_W-1:0]   alu_val,
    input logic [DATA_W-1:0]   lsb_val,
    input logic [ROB_ID_W-1:0] tag
  );
    return (alu_v && (alu_tag == tag)) ? alu_val : lsb_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_scheduler_first_one.sv
`default_nettype none
// ============================================================================
//  Module      : rs_first_one
//  Description : Lowest-set-bit priority encoder returning the bit index and
//                a found flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_first_one #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_scheduler
//  Description : ALU reservation station. Holds dispatched instructions until
//                both operands are known (snooping the ALU and LSB result
//                buses) and issues the lowest-index ready entry each cycle.
//                Optional macro ALU_RS_WAKEUP_BYPASS_EN lets an entry whose
//                last operand is broadcast this cycle issue immediately.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                dsp_valid,
  input  logic [OP_ID_W-1:0]  dsp_op_id,
  input  logic [ADDR_W-1:0]   dsp_inst_pc,
  input  logic [DATA_W-1:0]   dsp_vj,
  input  logic [DATA_W-1:0]   dsp_vk,
  input  logic                dsp_qj_busy,
  input  logic                dsp_qk_busy,
  input  logic [ROB_ID_W-1:0] dsp_qj,
  input  logic [ROB_ID_W-1:0] dsp_qk,
  input  logic [IMM_W-1:0]    dsp_imm,
  input  logic [ROB_ID_W-1:0] dsp_rob_id,
  output logic                rs_full,
  input  logic                cdb_alu_valid,
  input  logic                cdb_lsb_valid,
  input  logic [ROB_ID_W-1:0] cdb_alu_rob_id,
  input  logic [ROB_ID_W-1:0] cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]   cdb_alu_value,
  input  logic [DATA_W-1:0]   cdb_lsb_value,
  output logic                alu_input_valid,
  output logic [OP_ID_W-1:0]  alu_op_id,
  output logic [ADDR_W-1:0]   alu_inst_pc,
  output logic [DATA_W-1:0]   alu_reg_rs1,
  output logic [DATA_W-1:0]   alu_reg_rs2,
  output logic [IMM_W-1:0]    alu_imm,
  output logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic                roll_back_flag
);

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam logic C_BYPASS = 1'b1;
`else
  localparam logic C_BYPASS = 1'b0;
`endif

  // Entry state
  logic [RS_SIZE-1:0]  busy_q, busy_d;
  rs_entry_t           ent_q [RS_SIZE];
  rs_entry_t           ent_d [RS_SIZE];

  // Issue port registers
  logic                alu_valid_q, alu_valid_d;
  logic [OP_ID_W-1:0]  alu_op_q, alu_op_d;
  logic [ADDR_W-1:0]   alu_pc_q, alu_pc_d;
  logic [DATA_W-1:0]   alu_rs1_q, alu_rs1_d;
  logic [DATA_W-1:0]   alu_rs2_q, alu_rs2_d;
  logic [IMM_W-1:0]    alu_imm_q, alu_imm_d;
  logic [ROB_ID_W-1:0] alu_rob_q, alu_rob_d;

  // Snoop results per entry and for the incoming dispatch
  logic [RS_SIZE-1:0]  w_j_hit, w_k_hit, w_ready, w_free;
  logic [DATA_W-1:0]   w_j_val [RS_SIZE];
  logic [DATA_W-1:0]   w_k_val [RS_SIZE];
  logic                w_dj_hit, w_dk_hit;
  logic [DATA_W-1:0]   w_dj_val, w_dk_val;

  logic [RS_IDX_W-1:0] w_free_idx, w_issue_idx;
  logic                w_free_found, w_issue_found;

  // Compare every pending tag against both broadcast buses and form readiness
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_j_hit[i] = busy_q[i] && ent_q[i].qj_busy &&
                   cdb_hit(cdb_alu_valid, cdb_alu_rob_id, cdb_lsb_valid, cdb_lsb_rob_id, ent_q[i].qj);
      w_k_hit[i] = busy_q[i] && ent_q[i].qk_busy &&
                   cdb_hit(cdb_alu_valid, cdb_alu_rob_id, cdb_lsb_valid, cdb_lsb_rob_id, ent_q[i].qk);
      w_j_val[i] = cdb_value(cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_value, ent_q[i].qj);
      w_k_val[i] = cdb_value(cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_value, ent_q[i].qk);
      // With the bypass, an operand broadcast this cycle counts as known
      w_ready[i] = busy_q[i] &&
                   (!ent_q[i].qj_busy || (C_BYPASS && w_j_hit[i])) &&
                   (!ent_q[i].qk_busy || (C_BYPASS && w_k_hit[i]));
      w_free[i]  = !busy_q[i];
    end
    w_dj_hit = dsp_qj_busy &&
               cdb_hit(cdb_alu_valid, cdb_alu_rob_id, cdb_lsb_valid, cdb_lsb_rob_id, dsp_qj);
    w_dk_hit = dsp_qk_busy &&
               cdb_hit(cdb_alu_valid, cdb_alu_rob_id, cdb_lsb_valid, cdb_lsb_rob_id, dsp_qk);
    w_dj_val = cdb_value(cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_value, dsp_qj);
    w_dk_val = cdb_value(cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_value, dsp_qk);
  end

  rs_first_one #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
    .i_vec   (w_free),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_first_one #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_sel (
    .i_vec   (w_ready),
    .o_idx   (w_issue_idx),
    .o_found (w_issue_found)
  );

  // Free slots come from registered busy bits, so an issuing slot stays taken
  assign rs_full = !w_free_found;

  // Next-state: flush, or wakeup + issue + dispatch; rdy low holds everything
  always_comb begin
    busy_d      = busy_q;
    ent_d       = ent_q;
    alu_valid_d = alu_valid_q;
    alu_op_d    = alu_op_q;
    alu_pc_d    = alu_pc_q;
    alu_rs1_d   = alu_rs1_q;
    alu_rs2_d   = alu_rs2_q;
    alu_imm_d   = alu_imm_q;
    alu_rob_d   = alu_rob_q;
    if (rdy) begin
      if (roll_back_flag) begin
        busy_d      = '0;
        alu_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_j_hit[i]) begin
            ent_d[i].vj      = w_j_val[i];
            ent_d[i].qj_busy = 1'b0;
          end
          if (w_k_hit[i]) begin
            ent_d[i].vk      = w_k_val[i];
            ent_d[i].qk_busy = 1'b0;
          end
        end
        alu_valid_d = w_issue_found;
        if (w_issue_found) begin
          alu_op_d  = ent_q[w_issue_idx].op;
          alu_pc_d  = ent_q[w_issue_idx].pc;
          // A still-pending operand can only be here via the bypass path
          alu_rs1_d = ent_q[w_issue_idx].qj_busy ? w_j_val[w_issue_idx] : ent_q[w_issue_idx].vj;
          alu_rs2_d = ent_q[w_issue_idx].qk_busy ? w_k_val[w_issue_idx] : ent_q[w_issue_idx].vk;
          alu_imm_d = ent_q[w_issue_idx].imm;
          alu_rob_d = ent_q[w_issue_idx].rob_id;
          busy_d[w_issue_idx] = 1'b0;
        end
        if (dsp_valid && w_free_found) begin
          busy_d[w_free_idx]         = 1'b1;
          ent_d[w_free_idx].op       = dsp_op_id;
          ent_d[w_free_idx].pc       = dsp_inst_pc;
          ent_d[w_free_idx].vj       = w_dj_hit ? w_dj_val : dsp_vj;
          ent_d[w_free_idx].vk       = w_dk_hit ? w_dk_val : dsp_vk;
          ent_d[w_free_idx].qj_busy  = dsp_qj_busy && !w_dj_hit;
          ent_d[w_free_idx].qk_busy  = dsp_qk_busy && !w_dk_hit;
          ent_d[w_free_idx].qj       = dsp_qj;
          ent_d[w_free_idx].qk       = dsp_qk;
          ent_d[w_free_idx].imm      = dsp_imm;
          ent_d[w_free_idx].rob_id   = dsp_rob_id;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_pc_q    <= '0;
      alu_rs1_q   <= '0;
      alu_rs2_q   <= '0;
      alu_imm_q   <= '0;
      alu_rob_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      ent_q       <= ent_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_pc_q    <= alu_pc_d;
      alu_rs1_q   <= alu_rs1_d;
      alu_rs2_q   <= alu_rs2_d;
      alu_imm_q   <= alu_imm_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  assign alu_input_valid = alu_valid_q;
  assign alu_op_id       = alu_op_q;
  assign alu_inst_pc     = alu_pc_q;
  assign alu_reg_rs1     = alu_rs1_q;
  assign alu_reg_rs2     = alu_rs2_q;
  assign alu_imm         = alu_imm_q;
  assign alu_rob_id      = alu_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rs_scheduler
//  Description : Self-checking bench for alu_rs_scheduler with an in-bench
//                behavioural model of the reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  localparam int N = 16;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, rdy, dsp_valid, dsp_qj_busy, dsp_qk_busy;
  logic [OP_ID_W-1:0]  dsp_op_id;
  logic [ADDR_W-1:0]   dsp_inst_pc;
  logic [DATA_W-1:0]   dsp_vj, dsp_vk, cdb_alu_value, cdb_lsb_value;
  logic [ROB_ID_W-1:0] dsp_qj, dsp_qk, dsp_rob_id, cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [IMM_W-1:0]    dsp_imm;
  logic                cdb_alu_valid, cdb_lsb_valid, roll_back_flag;
  logic                rs_full, alu_input_valid;
  logic [OP_ID_W-1:0]  alu_op_id;
  logic [ADDR_W-1:0]   alu_inst_pc;
  logic [DATA_W-1:0]   alu_reg_rs1, alu_reg_rs2;
  logic [IMM_W-1:0]    alu_imm;
  logic [ROB_ID_W-1:0] alu_rob_id;

  always #5 clk = ~clk;

  alu_rs_scheduler #(.RS_SIZE(N), .RS_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dsp_valid(dsp_valid), .dsp_op_id(dsp_op_id), .dsp_inst_pc(dsp_inst_pc),
    .dsp_vj(dsp_vj), .dsp_vk(dsp_vk), .dsp_qj_busy(dsp_qj_busy), .dsp_qk_busy(dsp_qk_busy),
    .dsp_qj(dsp_qj), .dsp_qk(dsp_qk), .dsp_imm(dsp_imm), .dsp_rob_id(dsp_rob_id),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_lsb_rob_id(cdb_lsb_rob_id),
    .cdb_alu_value(cdb_alu_value), .cdb_lsb_value(cdb_lsb_value),
    .alu_input_valid(alu_input_valid), .alu_op_id(alu_op_id), .alu_inst_pc(alu_inst_pc),
    .alu_reg_rs1(alu_reg_rs1), .alu_reg_rs2(alu_reg_rs2), .alu_imm(alu_imm),
    .alu_rob_id(alu_rob_id), .roll_back_flag(roll_back_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic                m_busy [N];
  logic [OP_ID_W-1:0]  m_op   [N];
  logic [ADDR_W-1:0]   m_pc   [N];
  logic [DATA_W-1:0]   m_vj   [N];
  logic [DATA_W-1:0]   m_vk   [N];
  logic                m_qjb  [N];
  logic                m_qkb  [N];
  logic [ROB_ID_W-1:0] m_qj   [N];
  logic [ROB_ID_W-1:0] m_qk   [N];
  logic [IMM_W-1:0]    m_imm  [N];
  logic [ROB_ID_W-1:0] m_rob  [N];
  logic                m_valid = 1'b0;
  logic [OP_ID_W-1:0]  m_o_op  = '0;
  logic [ADDR_W-1:0]   m_o_pc  = '0;
  logic [DATA_W-1:0]   m_o_rs1 = '0;
  logic [DATA_W-1:0]   m_o_rs2 = '0;
  logic [IMM_W-1:0]    m_o_imm = '0;
  logic [ROB_ID_W-1:0] m_o_rob = '0;

  function automatic logic bc_hit(input logic [ROB_ID_W-1:0] t);
    return (cdb_alu_valid && cdb_alu_rob_id == t) || (cdb_lsb_valid && cdb_lsb_rob_id == t);
  endfunction

  function automatic logic [DATA_W-1:0] bc_val(input logic [ROB_ID_W-1:0] t);
    if (cdb_alu_valid && cdb_alu_rob_id == t) return cdb_alu_value;
    return cdb_lsb_value;
  endfunction

  function automatic logic known(input logic qb, input logic [ROB_ID_W-1:0] q);
    return !qb || (BYP && bc_hit(q));
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    int fr, iss;
    if (rst) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_valid = 1'b0; m_o_op = '0; m_o_pc = '0; m_o_rs1 = '0;
      m_o_rs2 = '0; m_o_imm = '0; m_o_rob = '0;
      return;
    end
    if (!rdy) return;
    if (roll_back_flag) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_valid = 1'b0;
      return;
    end
    fr = -1;
    iss = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!m_busy[i]) fr = i;
      if (m_busy[i] && known(m_qjb[i], m_qj[i]) && known(m_qkb[i], m_qk[i])) iss = i;
    end
    m_valid = (iss >= 0);
    if (iss >= 0) begin
      m_o_op  = m_op[iss];
      m_o_pc  = m_pc[iss];
      m_o_rs1 = m_qjb[iss] ? bc_val(m_qj[iss]) : m_vj[iss];
      m_o_rs2 = m_qkb[iss] ? bc_val(m_qk[iss]) : m_vk[iss];
      m_o_imm = m_imm[iss];
      m_o_rob = m_rob[iss];
      m_busy[iss] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && m_qjb[i] && bc_hit(m_qj[i])) begin m_vj[i] = bc_val(m_qj[i]); m_qjb[i] = 1'b0; end
      if (m_busy[i] && m_qkb[i] && bc_hit(m_qk[i])) begin m_vk[i] = bc_val(m_qk[i]); m_qkb[i] = 1'b0; end
    end
    if (dsp_valid && fr >= 0) begin
      m_busy[fr] = 1'b1;
      m_op[fr] = dsp_op_id; m_pc[fr] = dsp_inst_pc; m_imm[fr] = dsp_imm; m_rob[fr] = dsp_rob_id;
      m_qj[fr] = dsp_qj; m_qk[fr] = dsp_qk;
      m_qjb[fr] = dsp_qj_busy && !bc_hit(dsp_qj);
      m_qkb[fr] = dsp_qk_busy && !bc_hit(dsp_qk);
      m_vj[fr] = (dsp_qj_busy && bc_hit(dsp_qj)) ? bc_val(dsp_qj) : dsp_vj;
      m_vk[fr] = (dsp_qk_busy && bc_hit(dsp_qk)) ? bc_val(dsp_qk) : dsp_vk;
    end
  endtask

  task automatic idle();
    rdy = 1'b1; dsp_valid = 1'b0; dsp_qj_busy = 1'b0; dsp_qk_busy = 1'b0;
    cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0; roll_back_flag = 1'b0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dsp(input logic [OP_ID_W-1:0] op, input logic [DATA_W-1:0] vj,
                         input logic [DATA_W-1:0] vk, input logic qjb, input logic [ROB_ID_W-1:0] qj,
                         input logic qkb, input logic [ROB_ID_W-1:0] qk,
                         input logic [IMM_W-1:0] imm, input logic [ROB_ID_W-1:0] rob);
    dsp_valid = 1'b1; dsp_op_id = op; dsp_inst_pc = 32'h1000 + {27'd0, rob};
    dsp_vj = vj; dsp_vk = vk; dsp_qj_busy = qjb; dsp_qj = qj; dsp_qk_busy = qkb; dsp_qk = qk;
    dsp_imm = imm; dsp_rob_id = rob;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; rdy = 1'b0; dsp_valid = 1'b1; roll_back_flag = 1'b1;
    dsp_op_id = '0; dsp_inst_pc = '0; dsp_vj = '0; dsp_vk = '0; dsp_qj = '0; dsp_qk = '0;
    dsp_imm = '0; dsp_rob_id = '0; cdb_alu_rob_id = '0; cdb_lsb_rob_id = '0;
    cdb_alu_value = '0; cdb_lsb_value = '0;
    cycle(); cycle();
    rst = 1'b0; idle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", alu_input_valid); else n_pass++;
    n_checks++; if (rs_full !== 1'b0) $display("FAIL reset_full: got %0b want 0", rs_full); else n_pass++;
    n_checks++;
    if ({alu_op_id, alu_inst_pc, alu_reg_rs1, alu_reg_rs2, alu_imm, alu_rob_id} !== '0)
      $display("FAIL reset_outputs: got op=%0h pc=%0h rs1=%0h rs2=%0h imm=%0h rob=%0h want all 0",
               alu_op_id, alu_inst_pc, alu_reg_rs1, alu_reg_rs2, alu_imm, alu_rob_id);
    else n_pass++;
  endtask

  task automatic test_dispatch_ready();
    set_dsp(6'd1, 32'd5, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd7, 5'd3);
    cycle(); idle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL addi_t1_valid: got %0b want 0", alu_input_valid); else n_pass++;
    cycle();
    n_checks++; if (alu_input_valid !== 1'b1) $display("FAIL addi_t2_valid: got %0b want 1", alu_input_valid); else n_pass++;
    n_checks++;
    if (alu_reg_rs1 !== 32'd5 || alu_imm !== 32'd7 || alu_rob_id !== 5'd3)
      $display("FAIL addi_payload: got rs1=%0d imm=%0d rob=%0d want 5 7 3", alu_reg_rs1, alu_imm, alu_rob_id);
    else n_pass++;
    cycle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL addi_freed: got %0b want 0", alu_input_valid); else n_pass++;
  endtask

  task automatic test_wakeup_lsb();
    set_dsp(6'd2, 32'hdead, 32'd3, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 5'd6);
    cycle(); idle(); cycle(); cycle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL lsb_wait_valid: got %0b want 0", alu_input_valid); else n_pass++;
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 5'd2; cdb_lsb_value = 32'h10;
    cycle(); idle();
    n_checks++; if (alu_input_valid !== BYP) $display("FAIL lsb_t4_valid: got %0b want %0b", alu_input_valid, BYP); else n_pass++;
    cycle();
    n_checks++; if (alu_input_valid !== !BYP) $display("FAIL lsb_t5_valid: got %0b want %0b", alu_input_valid, !BYP); else n_pass++;
    n_checks++;
    if (alu_reg_rs1 !== 32'h10 || alu_reg_rs2 !== 32'd3 || alu_rob_id !== 5'd6)
      $display("FAIL lsb_payload: got rs1=%0h rs2=%0h rob=%0d want 10 3 6", alu_reg_rs1, alu_reg_rs2, alu_rob_id);
    else n_pass++;
  endtask

  task automatic test_capture_bypass();
    set_dsp(6'd3, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'd0, 5'd8);
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 5'd4; cdb_alu_value = 32'd9;
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 5'd4; cdb_lsb_value = 32'd77;
    cycle(); idle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL capture_t1_valid: got %0b want 0", alu_input_valid); else n_pass++;
    cycle();
    n_checks++;
    if (alu_input_valid !== 1'b1 || alu_reg_rs2 !== 32'd9 || alu_reg_rs1 !== 32'd1 || alu_rob_id !== 5'd8)
      $display("FAIL capture_issue: got v=%0b rs1=%0d rs2=%0d rob=%0d want 1 1 9 8",
               alu_input_valid, alu_reg_rs1, alu_reg_rs2, alu_rob_id);
    else n_pass++;
    cycle();
  endtask

  task automatic test_full();
    for (int i = 0; i < N; i++) begin
      set_dsp(6'd4, 32'd0, 32'd100 + 32'(i), 1'b1, 5'(8 + i), 1'b0, 5'd0, 32'(i), 5'(i));
      cycle();
    end
    idle();
    n_checks++; if (rs_full !== 1'b1) $display("FAIL full_set: got %0b want 1", rs_full); else n_pass++;
    set_dsp(6'd5, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd31);
    cycle(); idle();
    n_checks++;
    if (rs_full !== 1'b1 || alu_input_valid !== 1'b0)
      $display("FAIL full_drop: got full=%0b valid=%0b want 1 0", rs_full, alu_input_valid);
    else n_pass++;
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 5'd13; cdb_alu_value = 32'h55;
    cycle(); idle();
    n_checks++;
    if (alu_input_valid !== BYP || rs_full !== !BYP)
      $display("FAIL full_wake1: got valid=%0b full=%0b want %0b %0b", alu_input_valid, rs_full, BYP, !BYP);
    else n_pass++;
    cycle();
    n_checks++;
    if (alu_input_valid !== !BYP || rs_full !== 1'b0 || alu_rob_id !== 5'd5 ||
        alu_reg_rs1 !== 32'h55 || alu_reg_rs2 !== 32'd105)
      $display("FAIL full_wake2: got valid=%0b full=%0b rob=%0d rs1=%0h rs2=%0d want %0b 0 5 55 105",
               alu_input_valid, rs_full, alu_rob_id, alu_reg_rs1, alu_reg_rs2, !BYP);
    else n_pass++;
    roll_back_flag = 1'b1;
    cycle(); idle();
  endtask

  task automatic test_priority();
    for (int i = 0; i < 8; i++) begin
      set_dsp(6'd6, 32'd0, 32'd0, 1'b1, 5'(20 + i), 1'b0, 5'd0, 32'd0, 5'(i));
      cycle();
    end
    idle();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 5'd27; cdb_alu_value = 32'd70;
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 5'd22; cdb_lsb_value = 32'd20;
    cycle(); idle();
    n_checks++; if (alu_input_valid !== BYP) $display("FAIL prio_e1_valid: got %0b want %0b", alu_input_valid, BYP); else n_pass++;
    cycle();
    n_checks++;
    if (alu_input_valid !== 1'b1 || alu_rob_id !== (BYP ? 5'd7 : 5'd2))
      $display("FAIL prio_e2: got valid=%0b rob=%0d want 1 %0d", alu_input_valid, alu_rob_id, BYP ? 7 : 2);
    else n_pass++;
    cycle();
    n_checks++;
    if (alu_input_valid !== !BYP || alu_rob_id !== 5'd7 || alu_reg_rs1 !== 32'd70)
      $display("FAIL prio_e3: got valid=%0b rob=%0d rs1=%0d want %0b 7 70", alu_input_valid, alu_rob_id, alu_reg_rs1, !BYP);
    else n_pass++;
  endtask

  task automatic test_rollback();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 5'd20; cdb_alu_value = 32'd1;
    cycle(); idle();
    roll_back_flag = 1'b1;
    set_dsp(6'd7, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd30);
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 5'd21;
    cycle(); idle();
    n_checks++;
    if (alu_input_valid !== 1'b0 || rs_full !== 1'b0)
      $display("FAIL rollback_now: got valid=%0b full=%0b want 0 0", alu_input_valid, rs_full);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cdb_alu_valid = 1'b1; cdb_alu_rob_id = 5'(21 + i);
      cycle(); idle();
      n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL rollback_after%0d: got %0b want 0", i, alu_input_valid); else n_pass++;
    end
  endtask

  task automatic test_rdy_freeze();
    rdy = 1'b0;
    set_dsp(6'd8, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd12);
    cycle(); idle(); cycle(); cycle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL rdy_drop: got %0b want 0", alu_input_valid); else n_pass++;
    set_dsp(6'd8, 32'hab, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9);
    cycle(); idle(); rdy = 1'b0;
    cycle(); cycle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL rdy_frozen: got %0b want 0", alu_input_valid); else n_pass++;
    rdy = 1'b1; cycle();
    n_checks++;
    if (alu_input_valid !== 1'b1 || alu_rob_id !== 5'd9 || alu_reg_rs1 !== 32'hab)
      $display("FAIL rdy_resume: got valid=%0b rob=%0d rs1=%0h want 1 9 ab", alu_input_valid, alu_rob_id, alu_reg_rs1);
    else n_pass++;
    rdy = 1'b0; cycle();
    n_checks++; if (alu_input_valid !== 1'b1) $display("FAIL rdy_hold: got %0b want 1", alu_input_valid); else n_pass++;
    rdy = 1'b1; cycle();
    n_checks++; if (alu_input_valid !== 1'b0) $display("FAIL rdy_release: got %0b want 0", alu_input_valid); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rdy            = ($urandom_range(0, 9) != 0);
      roll_back_flag = ($urandom_range(0, 59) == 0);
      dsp_valid      = ($urandom_range(0, 1) == 1);
      dsp_op_id      = 6'($urandom);
      dsp_inst_pc    = $urandom;
      dsp_vj         = $urandom;
      dsp_vk         = $urandom;
      dsp_qj_busy    = ($urandom_range(0, 2) != 0);
      dsp_qk_busy    = ($urandom_range(0, 2) != 0);
      dsp_qj         = 5'($urandom_range(0, 7));
      dsp_qk         = 5'($urandom_range(0, 7));
      dsp_imm        = $urandom;
      dsp_rob_id     = 5'($urandom);
      cdb_alu_valid  = ($urandom_range(0, 2) == 0);
      cdb_lsb_valid  = ($urandom_range(0, 2) == 0);
      cdb_alu_rob_id = 5'($urandom_range(0, 7));
      cdb_lsb_rob_id = 5'($urandom_range(0, 7));
      cdb_alu_value  = $urandom;
      cdb_lsb_value  = $urandom;
      n_checks++;
      if (rs_full !== model_full()) $display("FAIL rand_full c%0d: got %0b want %0b", c, rs_full, model_full());
      else n_pass++;
      cycle();
      n_checks++;
      if (alu_input_valid !== m_valid) $display("FAIL rand_valid c%0d: got %0b want %0b", c, alu_input_valid, m_valid);
      else n_pass++;
      n_checks++;
      if ({alu_op_id, alu_inst_pc, alu_reg_rs1, alu_reg_rs2, alu_imm, alu_rob_id} !==
          {m_o_op, m_o_pc, m_o_rs1, m_o_rs2, m_o_imm, m_o_rob})
        $display("FAIL rand_payload c%0d: got rob=%0d rs1=%0h rs2=%0h want rob=%0d rs1=%0h rs2=%0h",
                 c, alu_rob_id, alu_reg_rs1, alu_reg_rs2, m_o_rob, m_o_rs1, m_o_rs2);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    test_reset();
    test_dispatch_ready();
    test_wakeup_lsb();
    test_capture_bypass();
    test_full();
    test_priority();
    test_rollback();
    test_rdy_freeze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
